// File: rtl/nck_stack_engine_pkg.sv
// Shared definitions for the binomial-coefficient stack engine:
// FSM state encoding and err bit positions.
package nck_stack_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_EVAL  = 3'd2,
        S_PUSH2 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int ERR_STK = 0;
    localparam int ERR_ACC = 1;

endpackage

// File: rtl/nck_stack_engine_lifo.sv
// LIFO stack with a combinational top-of-stack view; pushes while full and
// pops while empty are ignored.
module lifo_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] top_idx;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    // Wraps to the last slot when empty; top is don't-care then.
    assign top_idx = AW'(count_reg - 1'b1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[count_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (do_push) begin
            count_reg <= count_reg + 1'b1;
        end else if (do_pop) begin
            count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/nck_stack_engine.sv
// Computes C(n,k) by depth-first expansion of Pascal's rule on an explicit
// stack, summing base cases into a saturating accumulator.
module nck_stack_engine
    import nck_stack_engine_pkg::*;
#(
    parameter int N_W   = 5,
    parameter int ACC_W = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   n_in,
    input  logic [N_W-1:0]   k_in,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [1:0]       err
);

    localparam int W     = 2 * N_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SUM_W = ((ACC_W > N_W) ? ACC_W : N_W) + 1;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [ACC_W-1:0]   result_reg, result_next;
    logic [1:0]         err_reg, err_next;
    logic [N_W-1:0]     cn_reg, cn_next;
    logic [N_W-1:0]     ck_reg, ck_next;

    logic               stk_push, stk_pop, stk_clr;
    logic [W-1:0]       stk_din, stk_top;
    logic               stk_full, stk_empty;
    logic [CW-1:0]      stk_count;

    logic               base_case;
    logic [SUM_W-1:0]   add_val, sum;
    logic               acc_sat;

    lifo_stack #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .count (stk_count)
    );

    // Sum is wide enough that neither operand loses bits; any bit above
    // ACC_W means the accumulator overflowed.
    assign base_case = (ck_reg == '0) || (ck_reg == cn_reg);
    assign add_val   = base_case ? SUM_W'(1) : SUM_W'(cn_reg);
    assign sum       = SUM_W'(acc_reg) + add_val;
    assign acc_sat   = err_reg[ERR_ACC] || (|sum[SUM_W-1:ACC_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            acc_reg    <= '0;
            result_reg <= '0;
            err_reg    <= '0;
            cn_reg     <= '0;
            ck_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            cn_reg     <= cn_next;
            ck_reg     <= ck_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        err_next    = err_reg;
        cn_next     = cn_reg;
        ck_next     = ck_reg;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_clr     = 1'b0;
        stk_din     = '0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    err_next = '0;
                    if (k_in <= n_in) begin
                        acc_next   = '0;
                        stk_push   = 1'b1;
                        stk_din    = {n_in, k_in};
                        state_next = S_RUN;
                    end else begin
                        result_next = '0;
                        state_next  = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (stk_empty) begin
                    result_next = acc_reg;
                    state_next  = S_DONE;
                end else begin
                    stk_pop    = 1'b1;
                    cn_next    = stk_top[W-1:N_W];
                    ck_next    = stk_top[N_W-1:0];
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (base_case || (ck_reg == N_W'(1))) begin
                    if (acc_sat) begin
                        acc_next          = '1;
                        err_next[ERR_ACC] = 1'b1;
                    end else begin
                        acc_next = sum[ACC_W-1:0];
                    end
                    state_next = S_RUN;
                end else if (stk_full) begin
                    err_next[ERR_STK] = 1'b1;
                    result_next       = acc_reg;
                    state_next        = S_DONE;
                end else begin
                    stk_push   = 1'b1;
                    stk_din    = {cn_reg - N_W'(1), ck_reg - N_W'(1)};
                    state_next = S_PUSH2;
                end
            end
            S_PUSH2: begin
                if (stk_full) begin
                    err_next[ERR_STK] = 1'b1;
                    result_next       = acc_reg;
                    state_next        = S_DONE;
                end else begin
                    stk_push   = 1'b1;
                    stk_din    = {cn_reg - N_W'(1), ck_reg};
                    state_next = S_RUN;
                end
            end
            S_DONE: begin
                // An aborted expansion can leave entries behind.
                stk_clr    = (stk_count != '0);
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;
    assign err    = err_reg;

endmodule
